// File: rtl/init_ram_bank.sv
// rtl/init_ram_bank.sv - 32x8 RTC register-file RAM loaded by the RAM-init FSM, with host write/read port
module init_ram_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ROM_N  = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rom_to_ram,
    input  logic                         rom_enable,
    input  logic [ROM_N-1:0]             dir_rom,
    input  logic [DEPTH-1:0]             dir_ram,
    input  logic                         w_ram_enable,
    input  logic                         r_ram_enable,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    input  logic                         ext_we,
    input  logic [$clog2(DEPTH)-1:0]     ext_waddr,
    input  logic [DATA_W-1:0]            ext_wdata,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         init_done,
    output logic                         addr_err,
    output logic [$clog2(DEPTH+1)-1:0]   wr_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  mask;
    logic              rom_to_ram_q;

    logic [DATA_W-1:0] rom_val;
    logic [AW-1:0]     ram_idx;
    logic              ram_onehot;
    logic              rom_onehot;
    logic              init_attempt;
    logic              init_we;
    logic              init_bad;
    logic              burst_start;
    logic              host_we;
    logic [DEPTH-1:0]  mask_next;
    logic [CW-1:0]     count_base;
    logic [CW-1:0]     count_next;

    // RTC register image constants: st0..st2, time/date, timer, commands, enable, mask
    function automatic logic [DATA_W-1:0] rom_byte(input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'h00;
            1:       b = 8'h01;
            2:       b = 8'h02;
            3:       b = 8'h21;
            4:       b = 8'h22;
            5:       b = 8'h23;
            6:       b = 8'h24;
            7:       b = 8'h25;
            8:       b = 8'h26;
            9:       b = 8'h41;
            10:      b = 8'h42;
            11:      b = 8'h43;
            12:      b = 8'hF0;
            13:      b = 8'hF1;
            14:      b = 8'hF2;
            15:      b = 8'h08;
            16:      b = 8'h44;
            17:      b = 8'h10;
            default: b = 8'h00;
        endcase
        return DATA_W'(b);
    endfunction

    always_comb begin
        rom_val = '0;
        for (int i = 0; i < ROM_N; i++) begin
            if (dir_rom[i]) begin
                rom_val = rom_val | rom_byte(i);
            end
        end
    end

    always_comb begin
        ram_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dir_ram[i]) begin
                ram_idx = ram_idx | AW'(i);
            end
        end
    end

    assign ram_onehot = (dir_ram != '0) && ((dir_ram & (dir_ram - 1'b1)) == '0);
    assign rom_onehot = (dir_rom != '0) && ((dir_rom & (dir_rom - 1'b1)) == '0);

    // dir_ram == 0 is the FSM's terminal cycle, so it is neither a write nor an error
    assign init_attempt = rom_to_ram && rom_enable && w_ram_enable && (dir_ram != '0);
    assign init_we      = init_attempt && ram_onehot && rom_onehot;
    assign init_bad     = init_attempt && !(ram_onehot && rom_onehot);
    assign burst_start  = rom_to_ram && !rom_to_ram_q;
    assign host_we      = ext_we && !rom_to_ram;

    // A write landing on the burst-start cycle counts toward the new burst
    always_comb begin
        mask_next  = burst_start ? '0 : mask;
        count_base = burst_start ? '0 : wr_count;
        count_next = count_base;
        if (init_we) begin
            mask_next = mask_next | dir_ram;
            if (count_base != CW'(DEPTH)) begin
                count_next = count_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (init_we) begin
            mem[ram_idx] <= rom_val;
        end else if (host_we) begin
            mem[ext_waddr] <= ext_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_to_ram_q <= 1'b0;
            mask         <= '0;
            wr_count     <= '0;
            init_done    <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            rom_to_ram_q <= rom_to_ram;
            mask         <= mask_next;
            wr_count     <= count_next;
            if (burst_start) begin
                init_done <= 1'b0;
            end else if (&mask) begin
                init_done <= 1'b1;
            end
            if (init_bad) begin
                addr_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= r_ram_enable;
            if (r_ram_enable) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule
